// File: rtl/frame_pkg.sv
// Shared definitions for the frame transmitter and the UART-side unframer.
// The optional checksum byte is controlled by the FRAME_TX_CHECKSUM_EN macro.
package frame_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR0 = 3'd1;
    localparam logic [2:0] ST_HDR1 = 3'd2;
    localparam logic [2:0] ST_PAY  = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;

    // Frame header bytes
    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

    // Number of packed bytes needed to carry one row
    function automatic int unsigned bytes_per_row(input int unsigned linewidth,
                                                  input int unsigned pack_num);
        return (linewidth + pack_num - 1) / pack_num;
    endfunction

    // Counter width for a modulo-n counter (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_tx_counter.sv
// Lane/column/row position tracker for the frame transmitter.
// Advances once per accepted pixel and flags byte, row and frame ends.
module frame_tx_counter
    import frame_pkg::*;
#(
    parameter int unsigned pack_num_p     = 8,
    parameter int unsigned linewidth_px_p = 641,
    parameter int unsigned rows_p         = 480,
    localparam int unsigned lane_w_lp     = cnt_width(pack_num_p),
    localparam int unsigned col_w_lp      = cnt_width(linewidth_px_p),
    localparam int unsigned row_w_lp      = cnt_width(rows_p)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 step_i,
    output logic [lane_w_lp-1:0] lane_o,
    output logic                 byte_end_c_o,
    output logic                 frame_end_c_o
);

    logic [lane_w_lp-1:0] lane_q, lane_d;
    logic [col_w_lp-1:0]  col_q, col_d;
    logic [row_w_lp-1:0]  row_q, row_d;
    logic                 row_end_c;

    assign row_end_c     = (col_q == col_w_lp'(linewidth_px_p - 1));
    assign byte_end_c_o  = row_end_c | (lane_q == lane_w_lp'(pack_num_p - 1));
    assign frame_end_c_o = row_end_c & (row_q == row_w_lp'(rows_p - 1));
    assign lane_o        = lane_q;

    // Next position: a row end also closes the byte, a frame end clears everything
    always_comb begin
        lane_d = lane_q;
        col_d  = col_q;
        row_d  = row_q;
        if (step_i) begin
            if (frame_end_c_o) begin
                lane_d = '0;
                col_d  = '0;
                row_d  = '0;
            end else if (row_end_c) begin
                lane_d = '0;
                col_d  = '0;
                row_d  = row_q + 1'b1;
            end else begin
                col_d  = col_q + 1'b1;
                lane_d = byte_end_c_o ? '0 : lane_q + 1'b1;
            end
        end
    end

    // Position registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lane_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
        end else begin
            lane_q <= lane_d;
            col_q  <= col_d;
            row_q  <= row_d;
        end
    end

endmodule

// File: rtl/frame_tx.sv
// Transmit framer: packs a narrow pixel stream into row-aligned bytes,
// prefixed by two sync bytes and optionally followed by an XOR checksum
// byte when FRAME_TX_CHECKSUM_EN is defined.
module frame_tx
    import frame_pkg::*;
#(
    parameter int unsigned width_p        = 1,
    parameter int unsigned pack_num_p     = 8,
    parameter int unsigned linewidth_px_p = 641,
    parameter int unsigned rows_p         = 480,
    parameter logic [7:0]  sync0_p        = SYNC0,
    parameter logic [7:0]  sync1_p        = SYNC1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [7:0]         data_o,
    output logic               frame_done_o
);

    localparam int unsigned lane_w_lp = cnt_width(pack_num_p);

    logic [2:0]           state_q, state_d;
    logic [7:0]           data_q, data_d;
    logic [7:0]           acc_q, acc_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 slot_free_c;
    logic                 step_c;
    logic [7:0]           acc_new_c;
    logic [lane_w_lp-1:0] lane_c;
    logic                 byte_end_c;
    logic                 frame_end_c;
`ifdef FRAME_TX_CHECKSUM_EN
    logic [7:0]           csum_q, csum_d;
`endif

    // The single output slot can take a new byte when empty or draining
    assign slot_free_c  = ~valid_q | ready_i;
    assign ready_o      = (state_q == ST_PAY) & slot_free_c;
    assign step_c       = ready_o & valid_i;
    assign acc_new_c    = acc_q | (8'(data_i) << 3'(lane_c * width_p));
    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign frame_done_o = valid_q & ready_i & last_q;

    frame_tx_counter #(
        .pack_num_p     (pack_num_p),
        .linewidth_px_p (linewidth_px_p),
        .rows_p         (rows_p)
    ) u_counter (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .step_i        (step_c),
        .lane_o        (lane_c),
        .byte_end_c_o  (byte_end_c),
        .frame_end_c_o (frame_end_c)
    );

    // Framing FSM and output slot loading
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        acc_d   = acc_q;
        valid_d = valid_q & ~ready_i;
        last_d  = last_q & ~ready_i;
`ifdef FRAME_TX_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    state_d = ST_HDR0;
                end
            end
            ST_HDR0: begin
                if (slot_free_c) begin
                    data_d  = sync0_p;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
`ifdef FRAME_TX_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                    state_d = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (slot_free_c) begin
                    data_d  = sync1_p;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                if (step_c) begin
                    if (byte_end_c) begin
                        data_d  = acc_new_c;
                        valid_d = 1'b1;
                        last_d  = 1'b0;
                        acc_d   = 8'h00;
`ifdef FRAME_TX_CHECKSUM_EN
                        csum_d  = csum_q ^ acc_new_c;
                        if (frame_end_c) begin
                            state_d = ST_CSUM;
                        end
`else
                        if (frame_end_c) begin
                            last_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
`endif
                    end else begin
                        acc_d = acc_new_c;
                    end
                end
            end
            ST_CSUM: begin
`ifdef FRAME_TX_CHECKSUM_EN
                if (slot_free_c) begin
                    data_d  = csum_q;
                    valid_d = 1'b1;
                    last_d  = 1'b1;
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, output slot, accumulator and checksum registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            acc_q   <= 8'h00;
`ifdef FRAME_TX_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
`ifdef FRAME_TX_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: doc/frame_tx.md
Name: frame_tx

Overview:
- Transmit-side framer, the counterpart of the receive path's byte unpacking: turns the 1-bit-per-pixel edge-magnitude stream into framed UART bytes.
- Sits between the magnitude stage and the UART transmitter's AXIS slave port.
- Each frame is sent as:
  - two sync bytes;
  - row-aligned packed payload, with every row starting on a byte boundary;
  - an optional XOR checksum byte.

Parameters:
- width_p, 1, bits per pixel.
- pack_num_p, 8, pixels per output byte; width_p*pack_num_p must equal 8.
- linewidth_px_p, 641, pixels per row.
- rows_p, 480, rows per frame.
- sync0_p, 8'hA5, first header byte.
- sync1_p, 8'h5A, second header byte.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  pixel valid.
- ready_o  out  1  pixel accepted when valid_i & ready_o.
- data_i  in  width_p  pixel.
- valid_o  out  1  byte valid.
- ready_i  in  1  byte consumed when valid_o & ready_i.
- data_o  out  8  byte.
- frame_done_o  out  1  one-cycle pulse when the final byte of a frame is consumed.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-high; all state is cleared immediately on reset_i.
  - Reset values: valid_o=0, data_o=0, frame_done_o=0, ready_o=0; FSM in IDLE; all counters, the accumulator and the checksum are 0.
- Output register: single registered byte slot. "slot_free" = !valid_o | ready_i.
- Output hold rule: data_o and valid_o are held stable while valid_o & !ready_i.
- FSM states: IDLE, HDR0, HDR1, PAY, CSUM.
- IDLE:
  - ready_o=0.
  - On valid_i=1, go to HDR0. The pixel is not consumed.
- HDR0: when slot_free, load sync0_p, set valid_o, go to HDR1.
- HDR1: when slot_free, load sync1_p, go to PAY.
- PAY, handshake:
  - ready_o = slot_free.
  - Each accepted pixel is written into the accumulator at bit position lane*width_p.
  - The first pixel of a byte goes to the LSBs.
- PAY, byte completion:
  - A byte completes when lane==pack_num_p-1 or col==linewidth_px_p-1.
  - On completion, load {zero pad, accumulator with the new pixel} into data_o, set valid_o, and clear the accumulator.
  - Latency from the completing pixel's handshake to valid_o: 1 cycle.
  - Pad bits are 0.
  - With a 641-pixel row: 81 bytes per row; the last byte carries 1 pixel in bit 0 and 7 zero bits.
- Counters:
  - lane wraps at byte completion.
  - col wraps at linewidth_px_p-1.
  - row increments on col wrap.
- End of frame (last pixel of row rows_p-1):
  - Go to CSUM if the checksum feature is enabled, else to IDLE.
  - Counters reset to 0.
- CSUM: when slot_free, load the checksum, go to IDLE.
- frame_done_o: pulses on the cycle the frame's final byte (checksum or last payload byte) handshakes. Track this with a registered "last byte" flag.
- Back-to-back frames:
  - IDLE may start HDR0 in the cycle after frame completion even if the previous byte is still pending; slot_free governs progress.
  - No pixel is ever dropped; backpressure propagates fully.
- Stall stability: ready_o=0 whenever the slot is occupied and not draining. No combinational path from valid_i to ready_o.
- Reset mid-frame: the frame is discarded. The next frame restarts with headers.

Optional Feature:
- Macro: FRAME_TX_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR of every payload byte, folded in when loaded into data_o.
  - Cleared in HDR0.
  - CSUM state sends it as the final byte.
- Undefined:
  - No checksum register and no CSUM state.
  - Frame ends after the last payload byte.
- Frame length:
  - Enabled: 2 + rows_p*ceil(linewidth_px_p/pack_num_p) + 1 bytes.
  - Disabled: the same without the +1.

Decomposition:
- Shared package frame_pkg:
  - FSM state enum;
  - sync byte constants;
  - bytes_per_row function ceil(linewidth/pack_num);
  - counter widths via $clog2.
- The UART-side unframer uses the same package.
- Natural sub-module: frame_tx_counter, the lane/col/row counter with wrap and end-of-row/end-of-frame flags.

Test Plan:
All scenarios use linewidth_px_p=10, rows_p=2, with FRAME_TX_CHECKSUM_EN defined unless stated.
- Basic frame: pixels 1,0,1,1,0,0,0,1 | 1,1 per row with ready_i=1 -> bytes A5, 5A, 8D, 03, 8D, 03, checksum 00; frame_done_o pulses once with the last byte.
- Padding: row of ten 1s -> FF, 03. Upper 6 bits of the second byte are 0.
- Backpressure: hold ready_i=0 for 5 cycles mid-payload -> data_o stable, ready_o=0, no pixel loss, identical byte sequence.
- Checksum off (macro undefined): same stimulus -> 6 bytes, frame_done_o on byte 8D/03 (last payload byte).
- Async reset mid-frame: assert reset_i after 3 payload bytes -> valid_o drops immediately; the next frame begins with A5, 5A.
- Back-to-back frames: continuous valid_i for 40 pixels -> two complete frames, each with headers; total 14 bytes.
